// File: rtl/fir_rns_mac_pkg.sv
// Shared types, default moduli and modular arithmetic helpers for the RNS FIR.
package fir_rns_mac_pkg;

  localparam int RW     = 8;
  localparam int M0_DEF = 233;
  localparam int M1_DEF = 239;
  localparam int M2_DEF = 241;
  localparam int M3_DEF = 251;

  typedef logic [RW-1:0] residue_t;

  // r0 sits in the least significant bits
  typedef struct packed {
    residue_t r3;
    residue_t r2;
    residue_t r1;
    residue_t r0;
  } rns_word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Full product reduced mod m; operands may themselves be >= m.
  function automatic logic [31:0] mul_mod(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] m);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p % 64'(m));
  endfunction

  // Both operands are already < m, so one conditional subtract suffices.
  function automatic logic [31:0] add_mod(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] m);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) return 32'(s - {1'b0, m});
    return s[31:0];
  endfunction

endpackage

// File: rtl/fir_rns_mac_if.sv
// Sample, result and coefficient-load signals of the RNS FIR.
interface fir_rns_mac_if #(
  parameter int NTAPS = 8,
  parameter int W     = 8
);
  localparam int AW = $clog2(NTAPS);

  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [4*W-1:0] out_data;
  logic           coef_we;
  logic [AW-1:0]  coef_addr;
  logic [4*W-1:0] coef_data;
  logic           busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_rns_mac_lane.sv
// One residue channel: modular multiply-accumulate against a fixed modulus.
module fir_rns_mac_lane
  import fir_rns_mac_pkg::*;
#(
  parameter int W = 8,
  parameter int M = 233
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tap,
  input  logic [W-1:0] i_coef,
  output logic [W-1:0] o_acc_nxt
);

  logic [W-1:0] r_acc;
  logic [W-1:0] w_prod;

  assign w_prod    = W'(mul_mod(32'(i_tap), 32'(i_coef), 32'(M)));
  assign o_acc_nxt = W'(add_mod(32'(r_acc), 32'(w_prod), 32'(M)));

  // Accumulator: cleared when a sample is accepted, advanced once per MAC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= o_acc_nxt;
  end

endmodule

// File: rtl/fir_rns_mac.sv
// Time-multiplexed 4-channel RNS FIR: FSM, tap counter, delay line, coefficient file.
//
// state  | meaning
// S_IDLE | ready for a sample; coefficient writes allowed
// S_MAC  | one tap per cycle through all NTAPS taps
// S_OUT  | result held on out_data until out_ready
module fir_rns_mac
  import fir_rns_mac_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int W     = 8,
  parameter int M0    = M0_DEF,
  parameter int M1    = M1_DEF,
  parameter int M2    = M2_DEF,
  parameter int M3    = M3_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fir_rns_mac_if.slave  bus
);

  localparam int AW = $clog2(NTAPS);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_k;
  logic [4*W-1:0] r_tap  [NTAPS];
  logic [4*W-1:0] r_coef [NTAPS];
  logic [4*W-1:0] r_out_data;
  logic           r_in_ready;

  logic           w_accept;
  logic           w_last;
  logic           w_mac_en;
  logic           w_addr_ok;
  logic           w_coef_wr;
  logic           w_out_valid;
  logic           w_busy;
  logic [4*W-1:0] w_tap_k;
  logic [4*W-1:0] w_coef_k;
  logic [4*W-1:0] w_acc_nxt;

  assign w_accept  = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
  assign w_last    = (r_k == AW'(NTAPS - 1));
  assign w_mac_en  = (r_state == S_MAC);
  assign w_addr_ok = ({1'b0, bus.coef_addr} < (AW+1)'(NTAPS));
  assign w_coef_wr = (r_state == S_IDLE) && bus.coef_we && w_addr_ok;
  assign w_tap_k   = r_tap[r_k];
  assign w_coef_k  = r_coef[r_k];

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // in_ready is registered so it stays low throughout reset and rises on the first edge after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_in_ready <= 1'b0;
    else        r_in_ready <= (w_state_nxt == S_IDLE);
  end

  // Tap counter walks 0..NTAPS-1 during MAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_k <= '0;
    else if (w_accept) r_k <= '0;
    else if (w_mac_en) r_k <= w_last ? '0 : r_k + 1'b1;
  end

  // Delay line: newest sample enters tap 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) r_tap[i] <= '0;
    end else if (w_accept) begin
      for (int i = NTAPS - 1; i > 0; i--) r_tap[i] <= r_tap[i-1];
      r_tap[0] <= bus.in_data;
    end
  end

  // Coefficient file, writable only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_lane
    localparam int MC = (c == 0) ? M0 : (c == 1) ? M1 : (c == 2) ? M2 : M3;
    fir_rns_mac_lane #(.W(W), .M(MC)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_accept),
      .i_en      (w_mac_en),
      .i_tap     (w_tap_k[c*W +: W]),
      .i_coef    (w_coef_k[c*W +: W]),
      .o_acc_nxt (w_acc_nxt[c*W +: W])
    );
  end

  // Result capture on the final tap; held through OUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_out_data <= '0;
    else if (w_mac_en && w_last) r_out_data <= w_acc_nxt;
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = w_busy;

endmodule
